// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: packet-level command controller behind a UART receiver.
//
// Frames fixed 4-byte packets (SYNC, CMD, DATA, CHK) from the receiver's
// byte-complete flag, validates them and writes or clears a byte-wide
// register file.
//
// Optional feature macro: UART_CMD_TIMEOUT_EN.
// When defined, an inter-byte timeout aborts stalled packets with error code 3.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_rxcFlag   byte-complete flag from the receiver (rising edge = one byte)
//   i_rxByte    received byte, valid while i_rxcFlag is high
//   o_regs      flattened register file, register k at [8k+7:8k]
//   o_wrStrobe  one-cycle pulse when a packet commits
//   o_wrAddr    address of the last committed packet
//   o_errFlag   one-cycle pulse when a packet is rejected
//   o_errCode   last error: 0 none, 1 checksum, 2 illegal op, 3 timeout
//   o_busy      high while the packet FSM is outside idle
//   o_pktCount  committed packet count, wraps at 256
module uart_cmd_ctrl #(
    parameter int unsigned ADDR_BITS    = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 43400
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rxcFlag,
    input  logic [7:0]                    i_rxByte,
    output logic [8*(2**ADDR_BITS)-1:0]   o_regs,
    output logic                          o_wrStrobe,
    output logic [ADDR_BITS-1:0]          o_wrAddr,
    output logic                          o_errFlag,
    output logic [1:0]                    o_errCode,
    output logic                          o_busy,
    output logic [7:0]                    o_pktCount
);

    localparam int unsigned NumRegs = 2**ADDR_BITS;

    typedef enum logic [2:0] {StIdle, StCmd, StData, StChk, StCommit} state_e;

    state_e                 state_q, state_d;
    logic                   rxc_q;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             data_q, data_d;
    logic [8*NumRegs-1:0]   regs_q, regs_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic                   err_flag_q, err_flag_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   busy_q, busy_d;
    logic [7:0]             pkt_cnt_q, pkt_cnt_d;
    logic                   byte_ok;
    logic                   in_pkt;

    // A held-high flag counts once: only the 0->1 transition is a byte.
    assign byte_ok = i_rxcFlag & ~rxc_q;
    assign in_pkt  = (state_q == StCmd) || (state_q == StData) || (state_q == StChk);

`ifdef UART_CMD_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_flag_d  = 1'b0;
        err_code_d  = err_code_q;
        pkt_cnt_d   = pkt_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (byte_ok && (i_rxByte == SYNC_BYTE)) state_d = StCmd;
            end
            StCmd: begin
                if (byte_ok) begin
                    cmd_d   = i_rxByte;
                    state_d = StData;
                end
            end
            StData: begin
                if (byte_ok) begin
                    data_d  = i_rxByte;
                    state_d = StChk;
                end
            end
            StChk: begin
                if (byte_ok) begin
                    if (i_rxByte != (SYNC_BYTE ^ cmd_q ^ data_q)) begin
                        err_flag_d = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = StIdle;
                    end else if (cmd_q[7]) begin
                        err_flag_d = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = StIdle;
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                if (cmd_q[6]) begin
                    regs_d = '0;
                end else begin
                    regs_d[8*int'(cmd_q[ADDR_BITS-1:0]) +: 8] = data_q;
                end
                wr_strobe_d = 1'b1;
                wr_addr_d   = cmd_q[ADDR_BITS-1:0];
                pkt_cnt_d   = pkt_cnt_q + 8'd1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        // Counter restarts on every accepted byte; a byte in the expiry cycle wins.
        tmo_d = (in_pkt && !byte_ok) ? tmo_q + 16'd1 : 16'd0;
        if (in_pkt && !byte_ok && (tmo_q == 16'(TIMEOUT_CLKS - 1))) begin
            err_flag_d = 1'b1;
            err_code_d = 2'd3;
            state_d    = StIdle;
        end
`endif

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            rxc_q       <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_flag_q  <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rxc_q       <= i_rxcFlag;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_flag_q  <= err_flag_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    // Without the timeout, in_pkt has no consumer.
    logic unused_in_pkt;
    assign unused_in_pkt = in_pkt;
`endif

    assign o_regs     = regs_q;
    assign o_wrStrobe = wr_strobe_q;
    assign o_wrAddr   = wr_addr_q;
    assign o_errFlag  = err_flag_q;
    assign o_errCode  = err_code_q;
    assign o_busy     = busy_q;
    assign o_pktCount = pkt_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: directed packets plus randomized packets
// checked against a packet-level reference model.
module tb_uart_cmd_ctrl;

    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag;
    logic [7:0]  rxb;
    logic [31:0] o_regs;
    logic        o_wrStrobe;
    logic [1:0]  o_wrAddr;
    logic        o_errFlag;
    logic [1:0]  o_errCode;
    logic        o_busy;
    logic [7:0]  o_pktCount;

    uart_cmd_ctrl #(
        .ADDR_BITS    (2),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (T)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rxcFlag  (flag),
        .i_rxByte   (rxb),
        .o_regs     (o_regs),
        .o_wrStrobe (o_wrStrobe),
        .o_wrAddr   (o_wrAddr),
        .o_errFlag  (o_errFlag),
        .o_errCode  (o_errCode),
        .o_busy     (o_busy),
        .o_pktCount (o_pktCount)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strobes = 0;
    int errs = 0;
    int exp_strobes = 0;
    int exp_errs = 0;

    // Reference model state
    logic [7:0] m_regs [4];
    int         m_cnt;
    logic [1:0] m_code;
    logic [1:0] m_addr;

    always @(negedge clk) begin
        if (o_wrStrobe) strobes++;
        if (o_errFlag) errs++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] flat();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_cnt  = 0;
        m_code = 2'd0;
        m_addr = 2'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_regs"}, o_regs, flat());
        chk({tag, "_cnt"}, 32'(o_pktCount), 32'(m_cnt));
        chk({tag, "_code"}, 32'(o_errCode), 32'(m_code));
        chk({tag, "_addr"}, 32'(o_wrAddr), 32'(m_addr));
    endtask

    // Raise the flag with byte b for 'hold' cycles, then leave 'gap' idle cycles.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        flag = 1'b1;
        rxb  = b;
        repeat (hold) @(negedge clk);
        flag = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Full packet with cycle-exact strobe/error checks after the CHK byte.
    task automatic send_pkt(input string tag, input logic [7:0] s, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] k);
        logic commit;
        logic err;
        commit = 1'b0;
        err    = 1'b0;
        if (k != (s ^ c ^ d)) begin
            err = 1'b1; m_code = 2'd1;
        end else if (c[7]) begin
            err = 1'b1; m_code = 2'd2;
        end else begin
            commit = 1'b1;
            if (c[6]) for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            else m_regs[c[1:0]] = d;
            m_cnt  = (m_cnt + 1) % 256;
            m_addr = c[1:0];
        end
        exp_strobes += int'(commit);
        exp_errs    += int'(err);
        send_byte(s, 1, $urandom_range(0, 3));
        send_byte(c, 1, $urandom_range(0, 3));
        send_byte(d, 1, $urandom_range(0, 3));
        send_byte(k, 1, 0);
        chk({tag, "_errE0"}, 32'(o_errFlag), 32'(err));
        chk({tag, "_busyE0"}, 32'(o_busy), 32'(commit));
        chk({tag, "_stbE0"}, 32'(o_wrStrobe), 32'd0);
        @(negedge clk);
        chk({tag, "_stbE1"}, 32'(o_wrStrobe), 32'(commit));
        chk({tag, "_errE1"}, 32'(o_errFlag), 32'd0);
        @(negedge clk);
        chk({tag, "_stbE2"}, 32'(o_wrStrobe), 32'd0);
        chk_idle_state(tag);
    endtask

    initial begin
        logic [7:0] c, d, k, g;
        int s0;
        rst  = 1'b1;
        flag = 1'b0;
        rxb  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk_idle_state("reset");
        chk("reset_stb", 32'(o_wrStrobe), 32'd0);
        chk("reset_err", 32'(o_errFlag), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_pkt("write", 8'hA5, 8'h02, 8'h3C, 8'h9B);
        chk("write_reg2", 32'(o_regs[23:16]), 32'h3C);
        send_pkt("badchk", 8'hA5, 8'h01, 8'h55, 8'h00);
        send_pkt("illegal", 8'hA5, 8'hC0, 8'h11, 8'h74);
        send_pkt("clear", 8'hA5, 8'h40, 8'h00, 8'hE5);
        chk("clear_regs", o_regs, 32'd0);
        chk("clear_cnt", 32'(o_pktCount), 32'd2);

        // Garbage before a packet: exactly one commit.
        s0 = strobes;
        send_byte(8'h00, 1, 1);
        send_byte(8'hFF, 1, 1);
        send_pkt("garbage", 8'hA5, 8'h02, 8'h3C, 8'h9B);
        chk("garbage_commits", 32'(strobes - s0), 32'd1);

        // Held-high flag counts once per byte.
        s0 = strobes;
        send_byte(8'hA5, 5, 1);
        send_byte(8'h03, 5, 1);
        send_byte(8'h77, 5, 1);
        send_byte(8'hA5 ^ 8'h03 ^ 8'h77, 5, 3);
        m_regs[3] = 8'h77; m_cnt = (m_cnt + 1) % 256; m_addr = 2'd3;
        exp_strobes++;
        chk("hold_commits", 32'(strobes - s0), 32'd1);
        chk_idle_state("hold");

        // Reset mid-packet discards the partial packet silently.
        send_byte(8'hA5, 1, 1);
        send_byte(8'h02, 1, 1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk_idle_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        send_pkt("postrst", 8'hA5, 8'h01, 8'h5A, 8'hA5 ^ 8'h01 ^ 8'h5A);

`ifdef UART_CMD_TIMEOUT_EN
        send_byte(8'hA5, 1, 0);
        send_byte(8'h01, 1, 0);
        repeat (T - 1) @(negedge clk);
        chk("tmo_pre_err", 32'(o_errFlag), 32'd0);
        chk("tmo_pre_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        m_code = 2'd3;
        exp_errs++;
        chk("tmo_err", 32'(o_errFlag), 32'd1);
        chk("tmo_code", 32'(o_errCode), 32'd3);
        chk("tmo_busy", 32'(o_busy), 32'd0);
        send_pkt("tmo_after", 8'hA5, 8'h02, 8'h3C, 8'h9B);
`else
        // No timeout: the FSM waits indefinitely for the rest of the packet.
        send_byte(8'hA5, 1, 0);
        send_byte(8'h01, 1, 0);
        repeat (T + 20) @(negedge clk);
        chk("notmo_busy", 32'(o_busy), 32'd1);
        chk("notmo_code", 32'(o_errCode), 32'(m_code));
        send_byte(8'h3C, 1, 1);
        send_byte(8'hA5 ^ 8'h01 ^ 8'h3C, 1, 3);
        m_regs[1] = 8'h3C; m_cnt = (m_cnt + 1) % 256; m_addr = 2'd1;
        exp_strobes++;
        chk_idle_state("notmo");
`endif

        // Randomized packets, with optional garbage prefix and corrupted checksums.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, 1, $urandom_range(0, 2));
            end
            c = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            k = 8'hA5 ^ c ^ d;
            if ($urandom_range(0, 3) == 0) k = 8'($urandom_range(0, 255));
            send_pkt("rand", 8'hA5, c, d, k);
        end

        repeat (3) @(negedge clk);
        chk("strobe_total", 32'(strobes), 32'(exp_strobes));
        chk("err_total", 32'(errs), 32'(exp_errs));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
